montgomery_mult_arbiter: RTL and testbench

Shares one Montgomery multiplier core between two requesters. Requester 0 is the exponentiation squaring path; requester 1 is the exponentiation multiply path or a direct ARM multiply. The block arbitrates round-robin, latches the winner's operands, and sequences the core's start/done handshake. It returns the result to the winner through a valid/ready response channel. It sits between the exponentiation controller/wrapper and the single multiplier instance.

---
 rtl/montgomery_mult_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_montgomery_mult_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_mult_arbiter.sv
// Round-robin arbiter that shares one Montgomery multiplier core between two requesters.
// Optional watchdog on the core handshake is enabled by defining MONT_ARB_WATCHDOG_EN.
module montgomery_mult_arbiter #(
    parameter int WIDTH   = 512,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] modulus,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             core_start,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic [WIDTH-1:0] core_m,
    input  logic [WIDTH-1:0] core_result,
    input  logic             core_done,
    output logic             busy,
    output logic             error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] core_a_q, core_a_d;
    logic [WIDTH-1:0] core_b_q, core_b_d;
    logic [WIDTH-1:0] core_m_q, core_m_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic             grant1;

    // A lone requester always wins; on contention the rr pointer decides.
    assign grant1 = req1_valid & (~req0_valid | rr_q);

`ifdef MONT_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             error_q, error_d;
    logic             wd_expired;

    assign wd_expired = (wd_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_m_d     = core_m_q;
        rsp_result_d = rsp_result_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
`ifdef MONT_ARB_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
        error_d      = error_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    owner_d  = grant1;
                    core_a_d = grant1 ? req1_a : req0_a;
                    core_b_d = grant1 ? req1_b : req0_b;
                    core_m_d = modulus;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
`ifdef MONT_ARB_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (core_done) begin
                    rsp_result_d = core_result;
                    rsp0_valid_d = ~owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = S_RESP;
                end
`ifdef MONT_ARB_WATCHDOG_EN
                else if (wd_expired) begin
                    // A hung core still yields a response so the owner never stalls.
                    error_d      = 1'b1;
                    rsp_result_d = '0;
                    rsp0_valid_d = ~owner_q;
                    rsp1_valid_d = owner_q;
                    state_d      = S_RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
`endif
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    rr_d         = ~owner_q;
                    state_d      = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset as well, so every output reads 0
    // during reset rather than showing stale operands or results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            rr_q         <= 1'b0;
            owner_q      <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_m_q     <= '0;
            rsp_result_q <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_m_q     <= core_m_d;
            rsp_result_q <= rsp_result_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

`ifdef MONT_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            error_q  <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign req0_ready = (state_q == S_IDLE) & req0_valid & ~grant1;
    assign req1_ready = (state_q == S_IDLE) & grant1;
    assign core_start = (state_q == S_ISSUE);
    assign busy       = (state_q != S_IDLE);
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_m     = core_m_q;
    assign rsp_result = rsp_result_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

endmodule

// File: tb/tb_montgomery_mult_arbiter.sv
// Directed bench for montgomery_mult_arbiter; the core model answers (a | b) % m after a set delay.
// Define MONT_ARB_WATCHDOG_EN for both bench and RTL to exercise the watchdog scenario.
module tb_montgomery_mult_arbiter;

    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk;
    logic         resetn;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] modulus;
    logic         rsp0_valid, rsp1_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         core_start;
    logic [W-1:0] core_a, core_b, core_m;
    logic [W-1:0] core_result;
    logic         core_done;
    logic         busy, error;

    int n_cmp = 0;
    int n_bad = 0;

    // Core model state, updated only from tick() in the single stimulus thread.
    int           model_en    = 1;
    int           model_delay = 3;
    int           m_cnt       = 0;
    int           n_starts    = 0;
    logic [W-1:0] m_res;

    montgomery_mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .modulus    (modulus),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_m     (core_m),
        .core_result(core_result),
        .core_done  (core_done),
        .busy       (busy),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        core_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                core_done   = 1'b1;
                core_result = m_res;
            end
        end
        if (core_start === 1'b1 && model_en != 0) begin
            m_res = (core_a | core_b) % core_m;
            m_cnt = model_delay;
            n_starts++;
        end
    endtask

    task automatic wait_valid(input int which, input int max, output int cyc, output bit other_seen);
        cyc = -1;
        other_seen = 1'b0;
        for (int c = 1; c <= max; c++) begin
            tick();
            if ((which == 0 ? rsp1_valid : rsp0_valid) === 1'b1) other_seen = 1'b1;
            if ((which == 0 ? rsp0_valid : rsp1_valid) === 1'b1) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        core_done  = 1'b0;
        m_cnt      = 0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    function automatic logic [7+4*W-1:0] snapshot();
        return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, core_start, busy, error,
                rsp_result, core_a, core_b, core_m};
    endfunction

    task automatic test_reset();
        logic [7+4*W-1:0] snap;
        resetn = 1'b0;
        #1;
        snap = snapshot();
        n_cmp++;
        if (snap !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %0h, required 0", snap);
        end
        do_reset();
        #1;
        snap = snapshot();
        n_cmp++;
        if (snap !== '0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %0h, required 0", snap);
        end
    endtask

    task automatic test_single();
        int cyc;
        bit other;
        req0_a = 32'd3; req0_b = 32'd5; modulus = 32'd13;
        model_delay = 10;
        req0_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_ready: got %b, required 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        #1;
        n_cmp++;
        if ({core_start, req0_ready, core_a, core_b, core_m} !== {1'b1, 1'b0, 32'd3, 32'd5, 32'd13}) begin
            n_bad++;
            $display("FAIL single_issue: start=%b rdy=%b a=%0d b=%0d m=%0d, required 1 0 3 5 13",
                     core_start, req0_ready, core_a, core_b, core_m);
        end
        wait_valid(0, 40, cyc, other);
        n_cmp++;
        if (cyc !== 11 || other) begin
            n_bad++;
            $display("FAIL single_latency: got %0d cycles (rsp1 seen=%b), required 11 and 0", cyc, other);
        end
        n_cmp++;
        if (rsp_result !== 32'h7 || rsp1_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_result: got %0h rsp1=%b, required 7 and 0", rsp_result, rsp1_valid);
        end
        consume();
        n_cmp++;
        if ({rsp0_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL single_release: got %b, required 00", {rsp0_valid, busy});
        end
    endtask

    task automatic test_fairness();
        int  exp_tab[4] = '{19, 0, 19, 2};
        int  cyc;
        int  g;
        int  starts0;
        bit  other;
        do_reset();
        model_delay = 3;
        starts0 = n_starts;
        modulus = 32'd97;
        for (int i = 0; i < 4; i++) begin
            req0_a = 32'h10 + i; req0_b = 32'h3;
            req1_a = 32'h20 + i; req1_b = 32'h40;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            g = i % 2;
            n_cmp++;
            if ({req1_ready, req0_ready} !== (g == 1 ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("FAIL fair_grant%0d: ready1/0=%b, required grant %0d", i, {req1_ready, req0_ready}, g);
            end
            tick();
            wait_valid(g, 30, cyc, other);
            n_cmp++;
            if (cyc < 0 || other || rsp_result !== W'(exp_tab[i])) begin
                n_bad++;
                $display("FAIL fair_result%0d: cyc=%0d other=%b result=%0d, required %0d", i, cyc, other, rsp_result, exp_tab[i]);
            end
            consume();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_cmp++;
        if (n_starts - starts0 !== 4) begin
            n_bad++;
            $display("FAIL fair_starts: got %0d core_start pulses, required 4", n_starts - starts0);
        end
    endtask

    task automatic test_resp_hold();
        int cyc;
        bit other;
        req0_a = 32'd6; req0_b = 32'd9; modulus = 32'd11;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        req1_a = 32'd1; req1_b = 32'd2;
        req1_valid = 1'b1;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_busy_ready: req1_ready=%b, required 0", req1_ready);
        end
        wait_valid(0, 30, cyc, other);
        for (int i = 0; i < 20; i++) begin
            #1;
            n_cmp++;
            if ({rsp0_valid, busy, req1_ready, rsp_result} !== {1'b1, 1'b1, 1'b0, 32'd4}) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: valid=%b busy=%b rdy1=%b result=%0d, required 1 1 0 4",
                         i, rsp0_valid, busy, req1_ready, rsp_result);
            end
            tick();
        end
        consume();
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_next_accept: req1_ready=%b, required 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        wait_valid(1, 30, cyc, other);
        n_cmp++;
        if (cyc < 0 || other || rsp_result !== 32'd3) begin
            n_bad++;
            $display("FAIL hold_next_result: cyc=%0d other=%b result=%0d, required 3", cyc, other, rsp_result);
        end
        consume();
    endtask

    task automatic test_spurious();
        int cyc;
        bit other;
        core_done   = 1'b1;
        core_result = 32'hdead;
        tick();
        tick();
        n_cmp++;
        if ({busy, rsp0_valid, rsp1_valid, rsp_result} !== {3'b000, 32'd3}) begin
            n_bad++;
            $display("FAIL spur_idle: busy=%b v0=%b v1=%b result=%0h, required 0 0 0 3",
                     busy, rsp0_valid, rsp1_valid, rsp_result);
        end
        req0_a = 32'd4; req0_b = 32'd1; modulus = 32'd7;
        req0_valid = 1'b1;
        tick();
        req0_valid  = 1'b0;
        core_done   = 1'b1;
        core_result = 32'hbeef;
        tick();
        n_cmp++;
        if ({busy, rsp0_valid, rsp1_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL spur_issue: busy=%b v0=%b v1=%b, required 1 0 0", busy, rsp0_valid, rsp1_valid);
        end
        wait_valid(0, 30, cyc, other);
        n_cmp++;
        if (cyc < 0 || rsp_result !== 32'd5) begin
            n_bad++;
            $display("FAIL spur_result: cyc=%0d result=%0h, required 5", cyc, rsp_result);
        end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [7+4*W-1:0] snap;
        bit seen = 1'b0;
        req0_a = 32'd2; req0_b = 32'd1; modulus = 32'd5;
        model_delay = 6;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        snap = snapshot();
        n_cmp++;
        if (snap !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %0h, required 0", snap);
        end
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL midreset_late_done: activity seen=%b, required 0", seen);
        end
    endtask

    task automatic test_watchdog();
`ifdef MONT_ARB_WATCHDOG_EN
        int cyc;
        bit other;
        model_en = 0;
        req0_a = 32'd9; req0_b = 32'd9; modulus = 32'd13;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        wait_valid(0, 60, cyc, other);
        n_cmp++;
        if (cyc !== 17 || error !== 1'b1 || rsp_result !== '0) begin
            n_bad++;
            $display("FAIL wd_timeout: cyc=%0d error=%b result=%0h, required 17 1 0", cyc, error, rsp_result);
        end
        consume();
        model_en = 1;
        model_delay = 2;
        req1_a = 32'd1; req1_b = 32'd4;
        req1_valid = 1'b1;
        #1;
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_next_ready: req1_ready=%b, required 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        wait_valid(1, 30, cyc, other);
        n_cmp++;
        if (cyc < 0 || rsp_result !== 32'd5 || error !== 1'b1) begin
            n_bad++;
            $display("FAIL wd_next_result: cyc=%0d result=%0d error=%b, required 5 and 1", cyc, rsp_result, error);
        end
        consume();
`else
        #1;
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL error_tied: error=%b, required 0", error);
        end
`endif
    endtask

    initial begin
        resetn = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        modulus = '0; rsp_ready = 1'b0;
        core_result = '0; core_done = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_resp_hold();
        test_spurious();
        test_reset_mid();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
